// File: rtl/dmem_pkg.sv
// Shared definitions for the sub-word data memory: RV32I load/store funct3 codes and clear FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, RUN} dmem_state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the byte/halfword at the lane and sign- or zero-extends it per funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        rd       = '0;
        case (funct3)
            F3_B:    rd = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rd = {{16{half_sel[15]}}, half_sel};
            F3_W:    rd = word;
            F3_BU:   rd = {24'b0, byte_sel};
            F3_HU:   rd = {16'b0, half_sel};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/dmem_subword.sv
// RV32I data memory with byte-lane stores, extended loads and fault detection.
// Define DMEM_CLEAR_EN to zero the array with a DEPTH-cycle sweep after reset.
module dmem_subword
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH = 2048,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [2:0]  funct3,
    output logic [31:0] rd,
    output logic        fault,
    output logic        ready
);

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             range_err;
    logic             f3_err;
    logic             misalign;
    logic [3:0]       store_be;
    logic [31:0]      store_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      align_rd;

    assign word_idx  = a[IDX_W+1:2];
    assign lane      = a[1:0];
    assign range_err = |a[31:IDX_W+2];

    always_comb begin
        if (we) f3_err = funct3[2] || (funct3 == 3'b011);
        else    f3_err = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        misalign = ((funct3[1:0] == 2'b01) && a[0]) ||
                   ((funct3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        fault    = range_err || f3_err || misalign;
    end

    // Store data is replicated across lanes so the lane enables alone select the target bytes.
    always_comb begin
        store_be   = 4'h0;
        store_data = wd;
        case (funct3)
            F3_B: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{wd[7:0]}};
            end
            F3_H: begin
                store_be   = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wd[15:0]}};
            end
            F3_W:    store_be = 4'hF;
            default: store_be = 4'h0;
        endcase
    end

`ifdef DMEM_CLEAR_EN
    dmem_state_t      state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ready = (state_q == RUN);

    always_comb begin
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_q;
            wr_be   = 4'hF;
            wr_data = '0;
        end else begin
            wr_en   = we && !fault;
            wr_idx  = word_idx;
            wr_be   = store_be;
            wr_data = store_data;
        end
    end
`else
    logic unused_rst;

    assign unused_rst = rst;
    assign ready      = 1'b1;

    always_comb begin
        wr_en   = we && !fault;
        wr_idx  = word_idx;
        wr_be   = store_be;
        wr_data = store_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    dmem_load_align u_align (
        .word   (mem_q[word_idx]),
        .lane   (lane),
        .funct3 (funct3),
        .rd     (align_rd)
    );

    assign rd = (fault || !ready) ? '0 : align_rd;

endmodule

// File: tb/tb_dmem_subword.sv
// Self-checking bench for dmem_subword (DEPTH=16): table-driven vectors with a scoreboard queue.
module tb_dmem_subword;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;
    logic [2:0]  funct3 = F3_W;
    logic [31:0] rd;
    logic        fault;
    logic        ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_subword #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .wd     (wd),
        .we     (we),
        .funct3 (funct3),
        .rd     (rd),
        .fault  (fault),
        .ready  (ready)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        flt;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] f, input logic [31:0] ad,
                       input logic [31:0] d, input logic c, input logic [31:0] r, input logic fl);
        vec_t v;
        v.we = w; v.f3 = f; v.a = ad; v.wd = d; v.chk_rd = c; v.rd = r; v.flt = fl;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        we = v.we; funct3 = v.f3; a = v.a; wd = v.wd;
        e.chk_rd = v.chk_rd; e.rd = v.rd; e.flt = v.flt;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entries", name);
        end else begin
            e = sb.pop_front();
            check32({name, " fault"}, {31'b0, fault}, {31'b0, e.flt});
            if (e.chk_rd) check32({name, " rd"}, rd, e.rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef DMEM_CLEAR_EN
        check32("ready_in_reset", {31'b0, ready}, 32'd0);
        check32("rd_in_reset", rd, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check32("ready_mid_sweep", {31'b0, ready}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        we = 1'b1; a = 32'h4; wd = 32'hAAAA5555; funct3 = F3_W;
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 3) we = 1'b0;
        end
        we = 1'b0;
        check32("sweep_len", cnt, 32'd16);
`else
        check32("ready_in_reset", {31'b0, ready}, 32'd1);
        @(negedge clk) rst = 1'b0;
        #1 check32("ready_after_rst", {31'b0, ready}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            we = 1'b1; a = 32'(i * 4); wd = '0; funct3 = F3_W;
        end
        @(negedge clk) we = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) add(0, F3_W, 32'(i * 4), 0, 1, 32'h0, 0);

        add(1, F3_W,  32'h8, 32'h80FF7F01, 0, 0, 0);
        add(0, F3_B,  32'h8, 0, 1, 32'h00000001, 0);
        add(0, F3_B,  32'h9, 0, 1, 32'h0000007F, 0);
        add(0, F3_B,  32'hA, 0, 1, 32'hFFFFFFFF, 0);
        add(0, F3_B,  32'hB, 0, 1, 32'hFFFFFF80, 0);
        add(0, F3_BU, 32'h8, 0, 1, 32'h00000001, 0);
        add(0, F3_BU, 32'h9, 0, 1, 32'h0000007F, 0);
        add(0, F3_BU, 32'hA, 0, 1, 32'h000000FF, 0);
        add(0, F3_BU, 32'hB, 0, 1, 32'h00000080, 0);
        add(1, F3_W,  32'h8, 32'h11223344, 0, 0, 0);
        add(1, F3_H,  32'hA, 32'hDEADBEEF, 0, 0, 0);
        add(0, F3_W,  32'h8, 0, 1, 32'hBEEF3344, 0);
        add(0, F3_H,  32'hA, 0, 1, 32'hFFFFBEEF, 0);
        add(0, F3_HU, 32'hA, 0, 1, 32'h0000BEEF, 0);
        add(0, F3_H,  32'h8, 0, 1, 32'h00003344, 0);
        // faulting stores: dropped, rd forced to 0
        add(1, F3_W,  32'h6, 32'h55555555, 1, 32'h0, 1);
        add(1, F3_B,  32'h40, 32'h000000FF, 1, 32'h0, 1);
        add(1, 3'b100, 32'h8, 32'h99999999, 1, 32'h0, 1);
        add(1, 3'b011, 32'h8, 32'h99999999, 1, 32'h0, 1);
        add(1, 3'b111, 32'h8, 32'h99999999, 1, 32'h0, 1);
        add(0, F3_W,  32'h4, 0, 1, 32'h0, 0);
        add(0, F3_W,  32'h8, 0, 1, 32'hBEEF3344, 0);
        add(0, F3_W,  32'h0, 0, 1, 32'h0, 0);
        // faulting loads
        add(0, 3'b011, 32'h8, 0, 1, 32'h0, 1);
        add(0, 3'b110, 32'h8, 0, 1, 32'h0, 1);
        add(0, 3'b111, 32'h8, 0, 1, 32'h0, 1);
        add(0, F3_W,  32'h2, 0, 1, 32'h0, 1);
        add(0, F3_H,  32'h9, 0, 1, 32'h0, 1);
        add(0, F3_HU, 32'hB, 0, 1, 32'h0, 1);
        add(0, F3_W,  32'h40, 0, 1, 32'h0, 1);
        add(0, F3_B,  32'h80000008, 0, 1, 32'h0, 1);
        add(1, F3_B,  32'hD, 32'h1234565A, 0, 0, 0);
        add(0, F3_W,  32'hC, 0, 1, 32'h00005A00, 0);
        add(0, F3_B,  32'hD, 0, 1, 32'h0000005A, 0);
        // back-to-back lane merges on one word
        add(1, F3_B,  32'h10, 32'h000000AA, 0, 0, 0);
        add(1, F3_H,  32'h12, 32'h0000BBCC, 0, 0, 0);
        add(1, F3_B,  32'h11, 32'h000000F0, 0, 0, 0);
        add(0, F3_W,  32'h10, 0, 1, 32'hBBCCF0AA, 0);
        add(1, F3_W,  32'h3C, 32'hCAFEF00D, 0, 0, 0);
        add(0, F3_W,  32'h3C, 0, 1, 32'hCAFEF00D, 0);
        add(0, F3_B,  32'h3F, 0, 1, 32'hFFFFFFCA, 0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // same-cycle store and load: old data before the edge, new after
        @(negedge clk);
        we = 1'b1; a = 32'h0; wd = 32'h12345678; funct3 = F3_W;
        #1 check32("same_cycle_before", rd, 32'h0);
        @(posedge clk);
        #1 we = 1'b0;
        #1 check32("same_cycle_after", rd, 32'h12345678);
        check32("same_cycle_fault", {31'b0, fault}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
